// File: rtl/dbns_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// dbns_add_sequencer_if
// Request/response handshake bundle for the DBNS addition sequencer.
//   Request  : in_valid / in_ready, operands in_a1 / in_a2, caller tag in_tag
//   Response : out_valid / out_ready, digit stores out_store (6 x 4 bit),
//              carries out_cout (6 x 2 bit), returned tag out_tag
// Modports:
//   slave  - the sequencer side (accepts requests, produces responses)
//   master - the caller side (issues requests, consumes responses)
// -----------------------------------------------------------------------------
interface dbns_add_sequencer_if #(
  parameter int NUM_BITS = 5,
  parameter int TAG_W    = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] in_a1;
  logic [NUM_BITS-1:0] in_a2;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [23:0]         out_store;
  logic [11:0]         out_cout;
  logic [TAG_W-1:0]    out_tag;

  modport slave (
    input  in_valid, in_a1, in_a2, in_tag, out_ready,
    output in_ready, out_valid, out_store, out_cout, out_tag
  );

  modport master (
    output in_valid, in_a1, in_a2, in_tag, out_ready,
    input  in_ready, out_valid, out_store, out_cout, out_tag
  );
endinterface

// File: rtl/dbns_add_sequencer.sv
// -----------------------------------------------------------------------------
// dbns_add_sequencer
// Sequences one DBNS addition at a time: latches an operand pair onto the
// converter operand buses, waits the fixed converter + adder latency, captures
// the adder digit stores and carries, and presents them with the caller tag.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : request/response handshake (slave modport)
//   dp_a1, dp_a2 : registered operands to converter 1 / converter 2
//   dp_store     : adder digits {110,101,100,010,001,000}, 4 bits each
//   dp_cout      : adder carries {cout6..cout1}, 2 bits each
//   busy         : high whenever the sequencer is not idle
//   op_count     : completed operations, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module dbns_add_sequencer #(
  parameter int NUM_BITS = 5,
  parameter int CONV_LAT = 2,
  parameter int ADD_LAT  = 1,
  parameter int TAG_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  dbns_add_sequencer_if.slave bus,
  output logic [NUM_BITS-1:0] dp_a1,
  output logic [NUM_BITS-1:0] dp_a2,
  input  logic [23:0]         dp_store,
  input  logic [11:0]         dp_cout,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam int LAT   = CONV_LAT + ADD_LAT;
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  // A zero-latency datapath would need the capture on the accept edge itself,
  // which this controller does not support.
  if (LAT < 1) begin : g_lat_check
    $error("dbns_add_sequencer: CONV_LAT + ADD_LAT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [TAG_W-1:0]    tag_q;
  logic [23:0]         store_q;
  logic [11:0]         cout_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic [15:0]         op_cnt;
  logic [15:0]         op_cnt_nx;
  logic                accept;
  logic                capture;
  logic                retire;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // cnt was loaded with LAT on accept, so reaching 1 marks edge k+LAT.
        if (cnt == CNT_W'(1)) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          retire   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Written every cycle so the counter register always reloads from here.
    op_cnt_nx = (retire && (op_cnt != 16'hFFFF)) ? op_cnt + 16'd1 : op_cnt;
  end

  // Accept stage: operands to converters, tag held for the whole operation.
  // Capture stage: adder outputs frozen until the consumer takes them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dp_a1     <= '0;
      dp_a2     <= '0;
      tag_q     <= '0;
      store_q   <= '0;
      cout_q    <= '0;
      out_tag_q <= '0;
      op_cnt    <= '0;
    end else begin
      state  <= state_nx;
      op_cnt <= op_cnt_nx;
      if (accept) begin
        dp_a1 <= bus.in_a1;
        dp_a2 <= bus.in_a2;
        tag_q <= bus.in_tag;
        cnt   <= CNT_W'(LAT);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        store_q   <= dp_store;
        cout_q    <= dp_cout;
        out_tag_q <= tag_q;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !reset;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_store = store_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_tag   = out_tag_q;
  assign busy          = (state != S_IDLE);
  assign op_count      = op_cnt;

endmodule

// File: tb/tb_dbns_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dbns_add_sequencer
// Bench for dbns_add_sequencer with a two-register datapath stub whose output
// is a function of dp_a1/dp_a2, so a capture on the wrong edge sees stale data.
// Results are scoreboarded: expected values pushed at accept, popped when the
// consumer takes a result.
// -----------------------------------------------------------------------------
module tb_dbns_add_sequencer;
  localparam int NB  = 5;
  localparam int TW  = 4;
  localparam int CL  = 2;
  localparam int AL  = 1;
  localparam int LAT = CL + AL;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] dp_a1;
  logic [NB-1:0] dp_a2;
  logic [23:0]   dp_store;
  logic [11:0]   dp_cout;
  logic          busy;
  logic [15:0]   op_count;

  always #5 clock = ~clock;

  dbns_add_sequencer_if #(.NUM_BITS(NB), .TAG_W(TW)) bus ();

  dbns_add_sequencer #(
    .NUM_BITS(NB), .CONV_LAT(CL), .ADD_LAT(AL), .TAG_W(TW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .dp_a1    (dp_a1),
    .dp_a2    (dp_a2),
    .dp_store (dp_store),
    .dp_cout  (dp_cout),
    .busy     (busy),
    .op_count (op_count)
  );

  // Datapath stub: value for (9,7) is fixed, everything else is a mix of the
  // operands. Two register stages: valid for capture on edge k+3.
  function automatic logic [35:0] stub_fn(input logic [NB-1:0] a1, input logic [NB-1:0] a2);
    if (a1 == 5'd9 && a2 == 5'd7) return {24'h123456, 12'hABC};
    return {a1, a2, ~a1, ~a2, 4'(a1 + a2), a2, a1, 2'b11};
  endfunction

  logic [35:0] stub_p0;
  logic [35:0] stub_p1;
  always @(posedge clock) begin
    stub_p0 <= stub_fn(dp_a1, dp_a2);
    stub_p1 <= stub_p0;
  end
  assign {dp_store, dp_cout} = stub_p1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [23:0]   st;
    logic [11:0]   co;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t            q[$];
  exp_t            mon_e;
  int              acc_log[$];
  logic [TW-1:0]   tag_log[$];
  logic            prev_ov = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        {mon_e.st, mon_e.co} = stub_fn(bus.in_a1, bus.in_a2);
        mon_e.tag = bus.in_tag;
        mon_e.acc = cyc + 1;
        q.push_back(mon_e);
        acc_log.push_back(cyc + 1);
      end
      if (bus.out_valid && !prev_ov) begin
        if (q.size() == 0) check("unexpected_out_valid", bus.out_valid, 1'b0);
        else               check("accept_to_valid_latency", cyc - q[0].acc, LAT);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("result_without_op", bus.out_valid, 1'b0);
        end else begin
          mon_e = q.pop_front();
          check("sb_out_store", bus.out_store, mon_e.st);
          check("sb_out_cout",  bus.out_cout,  mon_e.co);
          check("sb_out_tag",   bus.out_tag,   mon_e.tag);
          tag_log.push_back(bus.out_tag);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_cnt = 16'd0;

  // Offer an operand pair and hold it until accepted; returns at k + 1ns.
  task automatic issue(input logic [NB-1:0] a1, input logic [NB-1:0] a2, input logic [TW-1:0] tag);
    logic ok;
    bus.in_a1    = a1;
    bus.in_a2    = a2;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    check("accept_seen", ok, 1'b1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [NB-1:0] a1, input logic [NB-1:0] a2, input logic [TW-1:0] tag,
                        input int hold, input logic noise,
                        input logic [23:0] exp_st, input logic [11:0] exp_co);
    logic ok;
    issue(a1, a2, tag);
    check("dp_a1_after_accept", dp_a1, a1);
    check("dp_a2_after_accept", dp_a2, a2);
    check("busy_in_wait", busy, 1'b1);
    if (noise) begin
      // Offers while busy must be ignored.
      bus.in_a1    = ~a1;
      bus.in_a2    = ~a2;
      bus.in_tag   = ~tag;
      bus.in_valid = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    check("out_valid_seen", ok, 1'b1);
    check("out_store", bus.out_store, exp_st);
    check("out_cout",  bus.out_cout,  exp_co);
    check("out_tag",   bus.out_tag,   tag);
    check("dp_a1_stable", dp_a1, a1);
    check("dp_a2_stable", dp_a2, a2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_out_store", bus.out_store, exp_st);
      check("stall_in_ready",  bus.in_ready,  1'b0);
    end
    @(posedge clock); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
    check("op_count", op_count, exp_cnt);
    check("idle_in_ready", bus.in_ready, 1'b1);
    check("idle_out_valid", bus.out_valid, 1'b0);
    check("retained_out_store", bus.out_store, exp_st);
    check("retained_dp_a1", dp_a1, a1);
  endtask

  typedef struct {
    logic [NB-1:0] a1;
    logic [NB-1:0] a2;
    logic [TW-1:0] tag;
    int            hold;
    logic          noise;
    logic [23:0]   st;
    logic [11:0]   co;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [35:0] sc;
    logic        ok;
    logic        seen;

    vecs[0] = '{5'd9,  5'd7,  4'd3,  0,  1'b0, 24'h123456, 12'hABC};
    vecs[1] = '{5'd31, 5'd0,  4'd15, 10, 1'b1, 24'h0, 12'h0};
    vecs[2] = '{5'd0,  5'd31, 4'd0,  2,  1'b0, 24'h0, 12'h0};
    vecs[3] = '{5'd21, 5'd10, 4'd5,  0,  1'b1, 24'h0, 12'h0};
    vecs[4] = '{5'd1,  5'd2,  4'd8,  1,  1'b0, 24'h0, 12'h0};
    for (int i = 1; i < 5; i++) begin
      sc = stub_fn(vecs[i].a1, vecs[i].a2);
      vecs[i].st = sc[35:12];
      vecs[i].co = sc[11:0];
    end

    bus.in_valid  = 1'b0;
    bus.in_a1     = '0;
    bus.in_a2     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset and idle state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in_ready_during_reset", bus.in_ready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy",      busy,          1'b0);
    check("rst_op_count",  op_count,      16'd0);
    check("rst_dp_a1",     dp_a1,         5'd0);
    check("rst_dp_a2",     dp_a2,         5'd0);
    check("rst_out_store", bus.out_store, 24'd0);
    check("rst_out_tag",   bus.out_tag,   4'd0);
    @(posedge clock); #1;

    // Table: single op, backpressure, ignored offers while busy
    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a1, vecs[i].a2, vecs[i].tag, vecs[i].hold, vecs[i].noise, vecs[i].st, vecs[i].co);

    // Back-to-back with out_ready tied high
    acc_log.delete();
    tag_log.delete();
    bus.out_ready = 1'b1;
    bus.in_a1 = 5'd4; bus.in_a2 = 5'd11; bus.in_tag = 4'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (bus.in_ready) begin ok = 1'b1; break; end
      end
      check("b2b_accept_seen", ok, 1'b1);
      @(posedge clock); #1;
      if (i == 0) begin bus.in_a1 = 5'd17; bus.in_a2 = 5'd6;  bus.in_tag = 4'd2; end
      if (i == 1) begin bus.in_a1 = 5'd30; bus.in_a2 = 5'd29; bus.in_tag = 4'd3; end
      if (i == 2) bus.in_valid = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (tag_log.size() >= 3) break;
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd3;
    check("b2b_result_count", tag_log.size(), 3);
    check("b2b_accept_count", acc_log.size(), 3);
    if (tag_log.size() >= 3) begin
      check("b2b_tag0", tag_log[0], 4'd1);
      check("b2b_tag1", tag_log[1], 4'd2);
      check("b2b_tag2", tag_log[2], 4'd3);
    end
    if (acc_log.size() >= 3) begin
      check("b2b_spacing01", acc_log[1] - acc_log[0], LAT + 2);
      check("b2b_spacing12", acc_log[2] - acc_log[1], LAT + 2);
    end
    check("b2b_op_count", op_count, exp_cnt);

    // Reset sampled on edge k+2 of an operation
    issue(5'd3, 5'd4, 4'd6);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      seen = seen | bus.out_valid;
    end
    check("midop_rst_no_out_valid", seen, 1'b0);
    check("midop_rst_op_count", op_count, 16'd0);
    check("midop_rst_busy", busy, 1'b0);
    check("midop_rst_in_ready", bus.in_ready, 1'b1);
    exp_cnt = 16'd0;
    @(posedge clock); #1;
    sc = stub_fn(5'd12, 5'd19);
    run_op(5'd12, 5'd19, 4'd9, 0, 1'b0, sc[35:12], sc[11:0]);

    // Saturation
    force dut.op_cnt = 16'hFFFE;
    @(posedge clock); #1;
    release dut.op_cnt;
    @(negedge clock);
    check("sat_preload", op_count, 16'hFFFE);
    exp_cnt = 16'hFFFE;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      sc = stub_fn(5'(i + 2), 5'(i + 20));
      run_op(5'(i + 2), 5'(i + 20), 4'(i + 10), 0, 1'b0, sc[35:12], sc[11:0]);
    end
    check("sat_final", op_count, 16'hFFFF);

    repeat (3) @(posedge clock);
    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
